// File: rtl/dmi_uart_bridge_if.sv
// rtl/dmi_uart_bridge_if.sv - DMI request/response handshake bundle between bridge and DM
interface dmi_uart_bridge_if;
  logic [40:0] dmi_req_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [33:0] dmi_resp_i;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;

  modport master (
    output dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o,
    input  dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i
  );

  modport slave (
    input  dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o,
    output dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i
  );
endinterface

// File: rtl/dmi_uart_bridge.sv
// rtl/dmi_uart_bridge.sv - 8N1 UART to DMI bridge: 6-byte request frames in, 5-byte responses out
module dmi_uart_bridge #(
  parameter int ClksPerBit  = 434,
  parameter int TimeoutBits = 160
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic uart_rx_i,
  output logic uart_tx_o,
  output logic dmi_rst_no,
  dmi_uart_bridge_if.master dmi
);

  localparam int CW = $clog2(ClksPerBit);
  localparam logic [CW-1:0] BitLast  = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] HalfLast = CW'(ClksPerBit / 2 - 1);
  localparam int TmoCycles = TimeoutBits * ClksPerBit;
  localparam int TW = $clog2(TmoCycles + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TmoCycles - 1);

  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, REQ, RESP, TX, RST} state_e;
  state_e state_q, state_d;

  // Third flop only serves edge detection; all reset high so an idle line never looks like a start.
  logic rx_s1, rx_s2, rx_s3;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx_i;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  logic          rx_busy, rx_strobe;
  logic [CW-1:0] rx_timer;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_byte;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_busy   <= 1'b0;
      rx_strobe <= 1'b0;
      rx_timer  <= '0;
      rx_bit    <= '0;
      rx_byte   <= '0;
    end else begin
      rx_strobe <= 1'b0;
      if (!rx_busy) begin
        if (rx_s3 && !rx_s2) begin
          rx_busy  <= 1'b1;
          rx_timer <= HalfLast;
          rx_bit   <= '0;
        end
      end else if (rx_timer != '0) begin
        rx_timer <= rx_timer - 1'b1;
      end else begin
        rx_timer <= BitLast;
        rx_bit   <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_busy   <= 1'b0;
          rx_strobe <= rx_s2;
        end else begin
          rx_byte <= {rx_s2, rx_byte[7:1]};
        end
      end
    end
  end

  logic          tx_busy, tx_start, tx_ready;
  logic [7:0]    tx_data;
  logic [CW-1:0] tx_timer;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_frame;

  // A new byte may load on the last cycle of the previous stop bit, so bytes go out back-to-back.
  assign tx_ready  = !tx_busy || (tx_timer == '0 && tx_bit == 4'd9);
  assign uart_tx_o = tx_busy ? tx_frame[0] : 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_busy  <= 1'b0;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_frame <= '1;
    end else if (tx_start && tx_ready) begin
      tx_busy  <= 1'b1;
      tx_frame <= {1'b1, tx_data, 1'b0};
      tx_timer <= BitLast;
      tx_bit   <= '0;
    end else if (tx_busy) begin
      if (tx_timer != '0) begin
        tx_timer <= tx_timer - 1'b1;
      end else if (tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_frame <= {1'b1, tx_frame[9:1]};
        tx_bit   <= tx_bit + 4'd1;
        tx_timer <= BitLast;
      end
    end
  end

  logic [1:0]    op_q, data_cnt;
  logic [6:0]    addr_q;
  logic [23:0]   data_q;
  logic [40:0]   req_q;
  logic [33:0]   resp_q;
  logic [2:0]    tx_idx;
  logic [TW-1:0] tmo_cnt;

  assign dmi.dmi_req_o        = req_q;
  assign dmi.dmi_req_valid_o  = (state_q == REQ);
  assign dmi.dmi_resp_ready_o = (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    dmi_rst_no = 1'b1;
    case (state_q)
      IDLE: begin
        if (rx_strobe) begin
          if (rx_byte == 8'h00 || rx_byte == 8'h01 || rx_byte == 8'h02) state_d = RX_ADDR;
          else if (rx_byte == 8'h80)                                     state_d = RST;
        end
      end
      RX_ADDR: begin
        if (rx_strobe)               state_d = RX_DATA;
        else if (tmo_cnt == TmoLast) state_d = IDLE;
      end
      RX_DATA: begin
        if (rx_strobe) begin
          if (data_cnt == 2'd3) state_d = REQ;
        end else if (tmo_cnt == TmoLast) begin
          state_d = IDLE;
        end
      end
      REQ:  if (dmi.dmi_req_ready_i) state_d = RESP;
      RESP: if (dmi.dmi_resp_valid_i) state_d = TX;
      TX: begin
        if (tx_idx != 3'd5) begin
          tx_start = 1'b1;
          case (tx_idx)
            3'd0:    tx_data = resp_q[9:2];
            3'd1:    tx_data = resp_q[17:10];
            3'd2:    tx_data = resp_q[25:18];
            3'd3:    tx_data = resp_q[33:26];
            default: tx_data = {6'b0, resp_q[1:0]};
          endcase
        end else if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      RST: begin
        // Only entered from IDLE with the transmitter free, so the pulse lasts exactly one cycle.
        if (tx_idx == 3'd0) begin
          dmi_rst_no = 1'b0;
          tx_start   = 1'b1;
          tx_data    = 8'hA5;
        end else if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      data_cnt <= '0;
      req_q    <= '0;
      resp_q   <= '0;
      tx_idx   <= '0;
      tmo_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && rx_strobe) op_q <= rx_byte[1:0];
      if (state_q == RX_ADDR && rx_strobe) begin
        addr_q   <= rx_byte[6:0];
        data_cnt <= '0;
      end
      if (state_q == RX_DATA && rx_strobe) begin
        data_q   <= {rx_byte, data_q[23:8]};
        data_cnt <= data_cnt + 2'd1;
        if (data_cnt == 2'd3) req_q <= {addr_q, op_q, rx_byte, data_q};
      end
      if (state_q == RESP && dmi.dmi_resp_valid_i) resp_q <= dmi.dmi_resp_i;
      if (state_q == TX || state_q == RST) begin
        if (tx_start && tx_ready) tx_idx <= tx_idx + 3'd1;
      end else begin
        tx_idx <= '0;
      end
      if ((state_q == RX_ADDR || state_q == RX_DATA) && !rx_strobe) tmo_cnt <= tmo_cnt + TW'(1);
      else                                                          tmo_cnt <= '0;
    end
  end

endmodule

// File: doc/dmi_uart_bridge.md
DMI_UART_BRIDGE -- requirements
Module: dmi_uart_bridge

Interface
REQ-001 Parameter ClksPerBit, default 434, clock cycles per UART bit period (50 MHz / 115200); SHALL be >= 4.
REQ-002 Parameter TimeoutBits, default 160, idle bit periods allowed between bytes of one request frame.
REQ-003 clk_i  in  1  single clock.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 uart_rx_i  in  1  asynchronous serial input, 8N1, idle high.
REQ-006 uart_tx_o  out  1  serial output, 8N1, idle high.
REQ-007 dmi_rst_no  out  1  active-low DMI reset pulse to the DM CSR block.
REQ-008 dmi_req_o  out  41  dm::dmi_req_t {addr[6:0], op[1:0], data[31:0]}.
REQ-009 dmi_req_valid_o  out  1  / dmi_req_ready_i  in  1: request handshake.
REQ-010 dmi_resp_i  in  34  dm::dmi_resp_t {data[31:0], resp[1:0]}.
REQ-011 dmi_resp_valid_i  in  1  / dmi_resp_ready_o  out  1: response handshake.

Function
REQ-012 RX: uart_rx_i SHALL pass a 2-flop synchroniser; a start bit is a synchronised high-to-low transition.
REQ-013 RX SHALL sample at mid-bit (ClksPerBit/2 after the start edge, then every ClksPerBit), LSB first; a start bit not low at mid-bit is ignored.
REQ-014 RX: stop bit sampled 0 SHALL discard the byte (framing error); no byte strobe is produced.
REQ-015 TX SHALL send start(0), 8 data bits LSB first, stop(1), each exactly ClksPerBit cycles; back-to-back bytes have no extra idle.
REQ-016 Request frame: byte0 = command, byte1 = addr (bit7 ignored), bytes2-5 = data, LSB first.
REQ-017 Commands: 0x00 nop, 0x01 read, 0x02 write (op = byte0[1:0]); 0x80 DMI reset; any other byte0 SHALL be discarded, FSM stays IDLE.
REQ-018 FSM states: IDLE, RX_ADDR, RX_DATA, REQ, RESP, TX, RST.
REQ-019 IDLE -> RX_ADDR on valid command 0x00-0x02; -> RST on 0x80.
REQ-020 RX_ADDR -> RX_DATA on byte; RX_DATA counts 4 bytes (2-bit counter), -> REQ after 4th.
REQ-021 RX_ADDR/RX_DATA: TimeoutBits bit periods without a completed byte SHALL abort to IDLE, frame dropped, nothing sent.
REQ-022 REQ: dmi_req_valid_o=1, dmi_req_o stable until dmi_req_ready_i=1 sampled; then valid drops next cycle, -> RESP.
REQ-023 RESP: dmi_resp_ready_o=1 until dmi_resp_valid_i=1; dmi_resp_i captured that cycle, -> TX.
REQ-024 TX: 5 bytes sent: data[7:0], [15:8], [23:16], [31:24], then {6'b0, resp}; -> IDLE after last stop bit.
REQ-025 RST: dmi_rst_no=0 for exactly one cycle, then single byte 0xA5 sent, -> IDLE.
REQ-026 Bytes received in REQ, RESP, TX or RST SHALL be discarded (no buffering).
REQ-027 dmi_req_valid_o and dmi_resp_ready_o SHALL never be high simultaneously; dmi_resp_valid_i outside RESP is ignored.
REQ-028 dmi_req_o SHALL hold the last assembled request when not valid.

Reset
REQ-029 On rst_ni=0, asynchronously: FSM IDLE, uart_tx_o=1, dmi_rst_no=1, dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_req_o=0, all counters 0.
REQ-030 Reset mid-frame or mid-transmission SHALL abandon it; uart_tx_o returns high immediately, no partial-byte completion after release.
REQ-031 Synchroniser flops SHALL reset to 1 so release with idle-high line produces no false start.

Verification (ClksPerBit=8, TimeoutBits=20)
REQ-032 Send 02 10 EF BE AD DE, ready after 3 cycles -> dmi_req_o {addr 0x10, op 2, data 0xDEADBEEF} held stable while valid; resp {0x00000000,0} -> TX 00 00 00 00 00.
REQ-033 Send 01 11 00 00 00 00, resp valid 5 cycles after ready, {0x00400082, 0} -> TX 82 00 40 00 00; resp_ready high only in RESP.
REQ-034 Send 80 -> dmi_rst_no low exactly 1 cycle, TX A5, no DMI request.
REQ-035 Send 02 10 EF then 25 bit periods silence -> abort, no request; next 01 04 00 00 00 00 handled normally.
REQ-036 Byte with stop bit 0, then invalid command 0x37 -> both discarded, FSM IDLE, uart_tx_o high.
REQ-037 Assert rst_ni mid RX_DATA and mid TX -> outputs at reset values same cycle, next full frame handled correctly.
